// File: rtl/jfpjc_pkg.sv
// jfpjc_pkg: shared widths, zigzag scan table and FSM states for the JPEG quantize/zigzag stage.
package jfpjc_pkg;
  localparam int COEF_W = 16;
  localparam int RECIP_W = 16;
  localparam int QCOEF_W = 12;
  localparam int BLOCK_SIZE = 64;
  localparam int ZIGZAG_TO_RASTER [BLOCK_SIZE] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
endpackage

// File: rtl/zigzag_rom.sv
// zigzag_rom: zigzag scan index to raster (row-major) address.
module zigzag_rom
  import jfpjc_pkg::*;
(
  input  logic [5:0] index,
  output logic [5:0] addr
);
  always_comb addr = 6'(ZIGZAG_TO_RASTER[index]);
endmodule

// File: rtl/jpeg_quantize_zigzag.sv
// jpeg_quantize_zigzag: zigzag read, reciprocal quantize, round, saturate and stream one 8x8 block.
// Optional DC prediction (index 0 sent as difference to previous block) with JPEG_QZ_DC_PRED_EN.
module jpeg_quantize_zigzag #(
  parameter int COEF_W = jfpjc_pkg::COEF_W,
  parameter int RECIP_W = jfpjc_pkg::RECIP_W,
  parameter int QCOEF_W = jfpjc_pkg::QCOEF_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  output logic               busy,
  output logic [5:0]         coef_read_addr,
  input  logic [COEF_W-1:0]  coef_read_data,
  output logic [5:0]         recip_read_addr,
  input  logic [RECIP_W-1:0] recip_read_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [QCOEF_W-1:0] out_data,
  output logic [5:0]         out_index,
  output logic               out_last,
  output logic               finished
);
  import jfpjc_pkg::*;
  localparam int P_W = COEF_W + RECIP_W + 1;
  localparam logic signed [P_W:0] QMAX = (P_W+1)'((1 <<< (QCOEF_W-1)) - 1);
  localparam logic signed [P_W:0] QMIN = -QMAX - 1;
  state_t state, state_n;
  logic [5:0] k, s1_index;
  logic s1_valid, held, stall, adv;
  logic [COEF_W-1:0] coef_hold;
  logic [RECIP_W-1:0] recip_hold, recip;
  logic signed [COEF_W-1:0] coef;
  logic signed [P_W-1:0] p;
  logic [P_W:0] mag, q_abs;
  logic signed [P_W:0] q;
  logic signed [QCOEF_W-1:0] q_sat, q_out;
  zigzag_rom u_rom (.index(k), .addr(coef_read_addr));
  assign recip_read_addr = coef_read_addr;
  assign busy = state != IDLE;
  assign stall = out_valid && !out_ready;
  assign adv = !stall;
  // The address moves on while a stall begins, so the word in S1 is parked until the stall clears.
  assign coef = held ? coef_hold : coef_read_data;
  assign recip = held ? recip_hold : recip_read_data;
  always_comb begin
    p = coef * $signed({1'b0, recip});
    mag = (P_W+1)'(p[P_W-1] ? -p : p);
    q_abs = (mag + (P_W+1)'(32768)) >> 16;
    q = recip == '0 ? (P_W+1)'(coef) : p[P_W-1] ? -q_abs : q_abs;
    q_sat = q > QMAX ? QMAX[QCOEF_W-1:0] : q < QMIN ? QMIN[QCOEF_W-1:0] : q[QCOEF_W-1:0];
  end
  always_comb
    state_n = state == IDLE ? (start ? RUN : IDLE)
            : state == RUN ? (adv && k == 6'(BLOCK_SIZE-1) ? DRAIN : RUN)
            : (out_valid && out_ready && out_last ? IDLE : DRAIN);
`ifdef JPEG_QZ_DC_PRED_EN
  logic signed [QCOEF_W-1:0] prev_dc, dc_hold;
  logic signed [QCOEF_W:0] diff;
  always_comb begin
    diff = {q_sat[QCOEF_W-1], q_sat} - {prev_dc[QCOEF_W-1], prev_dc};
    q_out = s1_index != '0 ? q_sat
          : diff[QCOEF_W] == diff[QCOEF_W-1] ? diff[QCOEF_W-1:0]
          : diff[QCOEF_W] ? {1'b1, {(QCOEF_W-1){1'b0}}} : {1'b0, {(QCOEF_W-1){1'b1}}};
  end
  always_ff @(posedge clock)
    if (reset) begin
      prev_dc <= '0;
      dc_hold <= '0;
    end else begin
      if (adv && s1_valid && s1_index == '0) dc_hold <= q_sat;
      if (out_valid && out_ready && out_index == '0) prev_dc <= dc_hold;
    end
`else
  assign q_out = q_sat;
`endif
  always_ff @(posedge clock)
    if (reset) begin
      state <= IDLE;
      k <= '0;
      s1_valid <= 1'b0;
      s1_index <= '0;
      held <= 1'b0;
      coef_hold <= '0;
      recip_hold <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_index <= '0;
      out_last <= 1'b0;
      finished <= 1'b0;
    end else begin
      state <= state_n;
      finished <= state == DRAIN && state_n == IDLE;
      held <= stall;
      if (stall && !held) begin
        coef_hold <= coef_read_data;
        recip_hold <= recip_read_data;
      end
      if (adv) begin
        k <= state == RUN ? k + 6'd1 : '0;
        s1_valid <= state == RUN;
        s1_index <= k;
        out_valid <= s1_valid;
        out_last <= s1_valid && s1_index == 6'(BLOCK_SIZE-1);
        if (s1_valid) begin
          out_data <= q_out;
          out_index <= s1_index;
        end
      end
    end
endmodule
